// File: rtl/series_control_unit_if.sv
// Control/status bundle between the series sequencer and its start/stop source and datapath.
// cycle_count (and CNT_W) exist only when CYCLE_COUNT_EN is defined.
interface series_control_unit_if #(
  parameter int TERM_W = 4
`ifdef CYCLE_COUNT_EN
  , parameter int CNT_W = 16
`endif
);
  logic              start;
  logic              stop;
  logic              abort;
  logic [3:0]        state;
  logic [TERM_W-1:0] term_idx;
  logic              busy;
  logic              load_en;
  logic              acc_en;
  logic              mul_en;
  logic              dist_en;
  logic              done;
  logic              timeout;
`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, stop, abort,
    input  state, term_idx, busy, load_en, acc_en, mul_en, dist_en, done, timeout, cycle_count
  );
  modport slave (
    input  start, stop, abort,
    output state, term_idx, busy, load_en, acc_en, mul_en, dist_en, done, timeout, cycle_count
  );
`else
  modport master (
    output start, stop, abort,
    input  state, term_idx, busy, load_en, acc_en, mul_en, dist_en, done, timeout
  );
  modport slave (
    input  start, stop, abort,
    output state, term_idx, busy, load_en, acc_en, mul_en, dist_en, done, timeout
  );
`endif
endinterface

// File: rtl/series_control_unit.sv
// Moore sequencer for a Taylor-series datapath: load, accumulate, re-multiply, distance step.
// Optional busy-cycle counter on cycle_count when CYCLE_COUNT_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start to rise
// ALERT  | start seen high, waiting for it to fall
// START  | load datapath, clear term index and timeout
// ACCUM  | accumulate current term, decide stop / last term / next term
// DIST   | final distance/error step
// REMULT | multi-cycle multiply for the next term
// DONE   | one-cycle completion pulse
module series_control_unit #(
  parameter int MAX_TERMS     = 8,
  parameter int TERM_W        = 4,
  parameter int REMULT_CYCLES = 2,
  parameter int RC_W          = 3
`ifdef CYCLE_COUNT_EN
  , parameter int CNT_W       = 16
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  series_control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    ALERT  = 4'd1,
    START  = 4'd2,
    ACCUM  = 4'd3,
    DIST   = 4'd4,
    REMULT = 4'd5,
    DONE   = 4'd6
  } state_t;

  localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(MAX_TERMS - 1);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(REMULT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [TERM_W-1:0] term_q, term_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      term_q    <= '0;
      rc_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      term_q    <= term_d;
      rc_q      <= rc_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = IDLE;
    term_d    = term_q;
    rc_d      = rc_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE:   state_d = bus.start ? ALERT : IDLE;
      ALERT: begin
        if (bus.abort)       state_d = IDLE;
        else if (!bus.start) state_d = START;
        else                 state_d = ALERT;
      end
      START: begin
        if (!bus.abort) begin
          state_d   = ACCUM;
          term_d    = '0;
          timeout_d = 1'b0;
        end
      end
      ACCUM: begin
        // stop outranks the last-term check, so a coincident stop never flags timeout
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.stop) begin
          state_d   = DIST;
          timeout_d = 1'b0;
        end else if (term_q == LAST_TERM) begin
          state_d   = DIST;
          timeout_d = 1'b1;
        end else begin
          state_d = REMULT;
          term_d  = term_q + TERM_W'(1);
          rc_d    = '0;
        end
      end
      REMULT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (rc_q == RC_LAST) begin
          state_d = ACCUM;
        end else begin
          state_d = REMULT;
          rc_d    = rc_q + RC_W'(1);
        end
      end
      DIST:    state_d = bus.abort ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.state    = state_q;
  assign bus.term_idx = term_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = (state_q == START) || (state_q == ACCUM) ||
                        (state_q == REMULT) || (state_q == DIST);
  assign bus.load_en  = (state_q == START);
  assign bus.acc_en   = (state_q == ACCUM);
  assign bus.mul_en   = (state_q == REMULT);
  assign bus.dist_en  = (state_q == DIST);
  assign bus.done     = (state_q == DONE);

`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // START seeds 1 so the value at DONE equals the number of busy cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!bus.abort) begin
      if (state_q == START) begin
        cnt_q <= CNT_W'(1);
      end else if ((state_q == ACCUM || state_q == REMULT || state_q == DIST) &&
                   (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.cycle_count = cnt_q;
`endif

endmodule
